// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU convolution core
package fpu_pkg;
  typedef logic [7:0] pixel_t;
  typedef logic signed [7:0] coef_t;
  typedef logic signed [20:0] acc_t;
  localparam int KERNEL_TAPS = 9;
  localparam int KERNEL_IDX_W = 4;
  localparam int SHIFT_W = 4;
  localparam int ACC_W = 21;
endpackage

// File: rtl/fpu_conv_lane.sv
// fpu_conv_lane: one output row's multiply / sum / shift+clamp pipeline (FPU_CONV_ABS_EN folds negative sums to |S|)
module fpu_conv_lane
  import fpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_v0,
  input  logic               i_v1,
  input  logic               i_v2,
  input  pixel_t             i_pix [KERNEL_TAPS],
  input  coef_t              i_k [KERNEL_TAPS],
  input  logic [SHIFT_W-1:0] i_shift,
  output pixel_t             o_pix
);
  logic signed [16:0] r_prod [KERNEL_TAPS];
  acc_t r_sum;
  acc_t w_sum;
  acc_t w_mag;
  acc_t w_t;
  pixel_t r_pix;
  // stage 1: zero-extended pixel times signed coefficient, captured with the incoming window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      for (int t = 0; t < KERNEL_TAPS; t++) r_prod[t] <= '0;
    else if (i_v0)
      for (int t = 0; t < KERNEL_TAPS; t++) r_prod[t] <= 17'($signed({1'b0, i_pix[t]})) * 17'(i_k[t]);
  end
  // adder tree over the nine sign-extended products
  always_comb begin
    w_sum = '0;
    for (int t = 0; t < KERNEL_TAPS; t++) w_sum = w_sum + acc_t'(r_prod[t]);
  end
  // stage 2: row sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sum <= '0;
    else if (i_v1) r_sum <= w_sum;
  end
  // optional magnitude, then arithmetic normalising shift
  always_comb begin
`ifdef FPU_CONV_ABS_EN
    w_mag = (r_sum < acc_t'(0)) ? -r_sum : r_sum;
`else
    w_mag = r_sum;
`endif
    w_t = w_mag >>> i_shift;
  end
  // stage 3: clamp to pixel range; holds its value between valid samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pix <= '0;
    else if (i_v2) r_pix <= (w_t < acc_t'(0)) ? 8'd0 : (w_t > acc_t'(255)) ? 8'hff : w_t[7:0];
  end
  assign o_pix = r_pix;
endmodule

// File: rtl/fpu_conv_core.sv
// fpu_conv_core: 3x3 programmable convolution over a 3-column window, latency 3 (FPU_CONV_ABS_EN enables |S| for edge kernels)
module fpu_conv_core
  import fpu_pkg::*;
#(
  parameter int COL_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [8*COL_WIDTH-1:0]       col0,
  input  logic [8*COL_WIDTH-1:0]       col1,
  input  logic [8*COL_WIDTH-1:0]       col2,
  input  logic                         kernel_wr,
  input  logic [KERNEL_IDX_W-1:0]      kernel_idx,
  input  logic [7:0]                   kernel_data,
  input  logic                         shift_wr,
  input  logic [SHIFT_W-1:0]           shift_data,
  output logic                         out_valid,
  output logic [8*(COL_WIDTH-2)-1:0]   out_pix,
  output logic                         busy
);
  coef_t r_k [KERNEL_TAPS];
  logic [SHIFT_W-1:0] r_shift;
  logic [SHIFT_W-1:0] r_sh1;
  logic [SHIFT_W-1:0] r_sh2;
  logic r_v1;
  logic r_v2;
  logic r_v3;
  // kernel and shift registers; reset to identity kernel, out-of-range indices dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < KERNEL_TAPS; t++) r_k[t] <= (t == 4) ? 8'sd1 : 8'sd0;
      r_shift <= '0;
    end else begin
      if (kernel_wr && kernel_idx < KERNEL_IDX_W'(KERNEL_TAPS)) r_k[kernel_idx] <= coef_t'(kernel_data);
      if (shift_wr) r_shift <= shift_data;
    end
  end
  // valid chain with the shift amount travelling alongside each sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_v1, r_v2, r_v3} <= '0;
      r_sh1 <= '0;
      r_sh2 <= '0;
    end else begin
      {r_v1, r_v2, r_v3} <= {in_valid, r_v1, r_v2};
      if (in_valid) r_sh1 <= r_shift;
      if (r_v1) r_sh2 <= r_sh1;
    end
  end
  assign out_valid = r_v3;
  assign busy = r_v1 | r_v2 | r_v3;
  genvar r, i;
  for (r = 1; r <= COL_WIDTH - 2; r++) begin : g_lane
    pixel_t w_pix [KERNEL_TAPS];
    for (i = 0; i < 3; i++) begin : g_tap
      assign w_pix[3*i]   = col0[8*(r-1+i) +: 8];
      assign w_pix[3*i+1] = col1[8*(r-1+i) +: 8];
      assign w_pix[3*i+2] = col2[8*(r-1+i) +: 8];
    end
    fpu_conv_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_v0    (in_valid),
      .i_v1    (r_v1),
      .i_v2    (r_v2),
      .i_pix   (w_pix),
      .i_k     (r_k),
      .i_shift (r_sh2),
      .o_pix   (out_pix[8*(r-1) +: 8])
    );
  end
endmodule

// File: tb/tb_fpu_conv_core.sv
// tb_fpu_conv_core: directed scoreboard bench for fpu_conv_core
module tb_fpu_conv_core;
  localparam int W = 10;
  localparam int OW = 8 * (W - 2);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [8*W-1:0] col0 = '0;
  logic [8*W-1:0] col1 = '0;
  logic [8*W-1:0] col2 = '0;
  logic kernel_wr = 1'b0;
  logic [3:0] kernel_idx = '0;
  logic [7:0] kernel_data = '0;
  logic shift_wr = 1'b0;
  logic [3:0] shift_data = '0;
  logic out_valid;
  logic busy;
  logic [OW-1:0] out_pix;
  int m_k [9];
  int m_sh;
  logic [OW-1:0] q [$];
  logic [OW-1:0] last_exp = '0;
  int n_cmp = 0;
  int n_bad = 0;

  fpu_conv_core #(.COL_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .col0(col0), .col1(col1), .col2(col2),
    .kernel_wr(kernel_wr), .kernel_idx(kernel_idx), .kernel_data(kernel_data),
    .shift_wr(shift_wr), .shift_data(shift_data),
    .out_valid(out_valid), .out_pix(out_pix), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input logic [8*W-1:0] c0, input logic [8*W-1:0] c1, input logic [8*W-1:0] c2);
    logic [OW-1:0] res;
    logic [8*W-1:0] c [3];
    int s;
    res = '0;
    c[0] = c0;
    c[1] = c1;
    c[2] = c2;
    for (int r = 1; r <= W - 2; r++) begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += m_k[3*i+j] * int'(c[j][8*(r-1+i) +: 8]);
`ifdef FPU_CONV_ABS_EN
      if (s < 0) s = -s;
`endif
      s = s >>> m_sh;
      res[8*(r-1) +: 8] = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
    end
    return res;
  endfunction

  function automatic logic [8*W-1:0] fill(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {W{b}};
  endfunction

  function automatic logic [8*W-1:0] rnd();
    logic [8*W-1:0] v;
    for (int k = 0; k < W; k++) v[8*k +: 8] = 8'($urandom_range(255));
    return v;
  endfunction

  task automatic win(input logic [8*W-1:0] c0, input logic [8*W-1:0] c1, input logic [8*W-1:0] c2);
    col0 = c0;
    col1 = c1;
    col2 = c2;
    in_valid = 1'b1;
    q.push_back(model(c0, c1, c2));
  endtask

  task automatic kw(input int idx, input int d);
    kernel_idx = 4'(idx);
    kernel_data = 8'(d);
    kernel_wr = 1'b1;
    if (idx <= 8) m_k[idx] = d;
  endtask

  task automatic sw(input int d);
    shift_data = 4'(d);
    shift_wr = 1'b1;
    m_sh = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kernel_wr = 1'b0;
    shift_wr = 1'b0;
  endtask

  task automatic load_kernel(input int k [9]);
    for (int t = 0; t < 9; t++) begin
      kw(t, k[t]);
      tick();
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 12 && (q.size() != 0 || busy); n++) tick();
    check(tag, OW'(q.size()), '0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) check("unexpected_out_valid", OW'(out_valid), '0);
      else begin
        last_exp = q.pop_front();
        check("out_pix", out_pix, last_exp);
      end
    end
  end

  initial begin
    int ident [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int ones [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int sob [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    logic [8*W-1:0] ramp;
    m_k = ident;
    m_sh = 0;
    for (int k = 0; k < W; k++) ramp[8*k +: 8] = 8'(k);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", OW'(out_valid), '0);
    check("rst_busy", OW'(busy), '0);
    check("rst_out_pix", out_pix, '0);
    rst_n = 1'b1;
    tick();
    // identity kernel on a ramp, with latency checks
    win('0, ramp, '0);
    tick();
    @(negedge clk);
    check("lat_c1_valid", OW'(out_valid), '0);
    check("lat_c1_busy", OW'(busy), 1);
    @(negedge clk);
    check("lat_c2_valid", OW'(out_valid), '0);
    @(negedge clk);
    check("lat_c3_valid", OW'(out_valid), 1);
    drain("ident_drain");
    repeat (3) tick();
    check("hold_out_pix", out_pix, last_exp);
    // box blur, normalised then saturating
    load_kernel(ones);
    sw(3);
    tick();
    win(fill(200), fill(200), fill(200));
    tick();
    drain("box_s3");
    sw(0);
    tick();
    win(fill(200), fill(200), fill(200));
    tick();
    drain("box_s0");
    // Sobel-x, negative sum
    load_kernel(sob);
    win(fill(100), fill(50), fill(0));
    tick();
    drain("sobel_s0");
    sw(1);
    tick();
    win(fill(100), fill(50), fill(0));
    tick();
    drain("sobel_s1");
    // kernel write coinciding with a window, and an out-of-range index
    load_kernel(ident);
    sw(0);
    tick();
    win('0, fill(50), '0);
    kw(4, 2);
    tick();
    drain("samecyc_old");
    win('0, fill(50), '0);
    tick();
    drain("samecyc_new");
    kw(12, 7);
    tick();
    win('0, fill(50), '0);
    tick();
    drain("idx_oob");
    // three back-to-back windows with a shift change mid-stream
    kw(0, 1);
    kw(0, 1);
    tick();
    win(rnd(), rnd(), rnd());
    tick();
    @(negedge clk);
    check("b2b_c1_busy", OW'(busy), 1);
    check("b2b_c1_valid", OW'(out_valid), '0);
    win(rnd(), rnd(), rnd());
    sw(2);
    tick();
    @(negedge clk);
    check("b2b_c2_busy", OW'(busy), 1);
    check("b2b_c2_valid", OW'(out_valid), '0);
    win(rnd(), rnd(), rnd());
    tick();
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("b2b_c%0d_busy", c), OW'(busy), 1);
      check($sformatf("b2b_c%0d_valid", c), OW'(out_valid), 1);
    end
    @(negedge clk);
    check("b2b_c6_busy", OW'(busy), '0);
    check("b2b_c6_valid", OW'(out_valid), '0);
    drain("b2b_drain");
    // asynchronous reset with two samples in flight
    load_kernel(sob);
    win(rnd(), rnd(), rnd());
    tick();
    win(rnd(), rnd(), rnd());
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", OW'(out_valid), '0);
    check("arst_busy", OW'(busy), '0);
    check("arst_out_pix", out_pix, '0);
    q.delete();
    m_k = ident;
    m_sh = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("post_rst_valid", OW'(out_valid), '0);
    win(rnd(), rnd(), rnd());
    tick();
    drain("post_rst_ident");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
